keccak_squeeze: RTL and testbench
=================================

Name: keccak_squeeze

Overview:
- Output (reader) end of the SHAKE sponge: takes the 5x5x64 Keccak state after the permutation rounds and streams the rate lanes out as 64-bit words over a valid/ready interface.
- When the rate is exhausted and more output is needed, it requests another permutation and waits for the new state.
- Sits after the round datapath (theta/rho/pi/chi/iota) and feeds XOF consumers such as sampling and expansion units.

Parameters:
- RATE_LANES, 21, number of 64-bit rate lanes per block (21 = SHAKE128, 17 = SHAKE256); legal range 1..25.
- LEN_W, 16, width of the requested output length in lanes.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  begin a squeeze; sampled only in IDLE.
- out_len_i  input  LEN_W  total number of 64-bit lanes to output; sampled with start_i.
- state_i  input  64 x [4:0][4:0]  Keccak state, indexed state_i[x][y].
- state_valid_i  input  1  state_i holds a freshly permuted state; sampled only in WAIT_STATE.
- perm_req_o  output  1  one-cycle pulse requesting the next permutation.
- out_data_o  output  64  current output lane.
- out_valid_o  output  1  out_data_o is valid.
- out_ready_i  input  1  consumer accepts the lane.
- out_last_o  output  1  the current lane is the final one of the request.
- busy_o  output  1  the FSM is not in IDLE.
- done_o  output  1  one-cycle pulse when the request completes.

Behaviour:
- Reset (async, rst low): FSM = IDLE; state buffer, lane index and remaining counter cleared. All outputs are 0, including out_data_o.
- Lane order: lane L maps to x = L mod 5, y = L div 5, word = buf[x][y]. L runs from 0 to RATE_LANES-1. There is no byte swapping.
- IDLE:
  - start_i=1 with out_len_i>0: load remaining = out_len_i, set lane = 0, go to WAIT_STATE.
  - start_i=1 with out_len_i=0: done_o pulses in the next cycle and the FSM stays in IDLE.
  - state_valid_i is ignored.
- WAIT_STATE:
  - On state_valid_i=1, latch all 25 lanes of state_i into the internal buffer and go to STREAM. The permutation may overwrite state_i after this.
  - Timing: start_i at cycle t, state_valid_i at t+1, out_valid_o high at t+2.
- STREAM:
  - out_valid_o=1; out_data_o = buffer lane[lane].
  - out_last_o = (remaining == 1).
  - out_data_o, out_last_o and out_valid_o stay stable while out_ready_i=0.
- On a handshake (out_valid_o & out_ready_i):
  - remaining decrements.
  - If remaining was 1: go to IDLE; done_o pulses in the next cycle; no perm_req_o.
  - Else if lane == RATE_LANES-1: lane = 0; perm_req_o pulses in the next cycle; go to WAIT_STATE.
  - Else: lane increments.
- Throughput: one lane per cycle while out_ready_i is held high.
- Boundary cases:
  - start_i while busy is ignored.
  - state_valid_i outside WAIT_STATE is ignored.
  - If out_len_i is an exact multiple of RATE_LANES, there is no trailing perm_req_o.
  - Reset in any state returns the block to IDLE immediately; partial output is abandoned.
- Width: remaining is LEN_W bits; lane is ceil(log2(RATE_LANES)) bits; neither counter wraps.

Decomposition:
- keccak_pkg (shared) holds:
  - lane_t: logic [63:0].
  - state_t: lane_t [4:0][4:0].
  - SHAKE128_RATE_LANES = 21 and SHAKE256_RATE_LANES = 17.
  - The lane_xy function mapping L to (x, y).
  - The squeeze FSM state enum.
- Sub-module keccak_lane_sel: a combinational 25:1 lane multiplexer indexed by L, reusable on the absorb side.

Test Plan:
- state[x][y] = 64'h0000_0000_0000_00{x,y}, RATE_LANES=21, len=3, ready held high -> outputs 0x00, 0x10, 0x20 on consecutive cycles; out_last_o on the third; done_o one cycle later; perm_req_o never asserted.
- len=21 -> 21 lanes, the last being state[0][4]; out_last_o on lane 20; done_o; no perm_req_o.
- len=22 -> perm_req_o pulses the cycle after the lane-20 handshake. Drive state_valid_i 4 cycles later with a new state' -> one lane state'[0][0] with out_last_o; then done_o.
- Backpressure: len=5, out_ready_i low for 5 cycles mid-stream -> data and last stay stable; no lane lost or duplicated; total 5 handshakes.
- len=0 start -> done_o pulses next cycle; out_valid_o, busy_o and perm_req_o stay 0.
- Assert rst low during STREAM (lane 7) -> all outputs 0 immediately. A later state_valid_i pulse in IDLE is ignored, and a new start with len=2 outputs lanes 0 and 1 of the new state.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak types, SHAKE rate constants, lane addressing and squeeze FSM states.
package keccak_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0][4:0] state_t;

  localparam int unsigned SHAKE128_RATE_LANES = 21;
  localparam int unsigned SHAKE256_RATE_LANES = 17;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } lane_xy_t;

  typedef enum logic [1:0] {
    SQ_IDLE,
    SQ_WAIT_STATE,
    SQ_STREAM
  } sq_state_t;

  // Linear lane L sits at x = L mod 5, y = L div 5.
  function automatic lane_xy_t lane_xy(input logic [4:0] l);
    lane_xy_t r;
    r.x = 3'(l % 5);
    r.y = 3'(l / 5);
    return r;
  endfunction

endpackage

// File: rtl/keccak_lane_sel.sv
// Combinational 25:1 lane multiplexer: picks state[x][y] for linear lane index L.
module keccak_lane_sel
  import keccak_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] lane_idx,
  output lane_t      lane
);

  lane_xy_t xy;

  always_comb begin
    xy   = lane_xy(lane_idx);
    lane = '0;
    if (lane_idx < 5'd25) begin
      lane = state[xy.x][xy.y];
    end
  end

endmodule

// File: rtl/keccak_squeeze.sv
// SHAKE sponge squeeze: streams rate lanes of the permuted state as 64-bit words
// and requests a further permutation whenever the rate is exhausted.
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_LANES = SHAKE128_RATE_LANES,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] out_len_i,
  input  state_t           state_i,
  input  logic             state_valid_i,
  output logic             perm_req_o,
  output lane_t            out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned LANE_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATE_LANES - 1);
  localparam logic [LEN_W-1:0]  ONE_LEFT  = LEN_W'(1);

  sq_state_t         state_q, state_d;
  state_t            state_buf;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              perm_req_q, perm_req_d;
  logic              done_q, done_d;
  logic              load_buf;
  lane_t             sel_lane;

  keccak_lane_sel u_lane_sel (
    .state    (state_buf),
    .lane_idx (5'(lane_q)),
    .lane     (sel_lane)
  );

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    remaining_d = remaining_q;
    perm_req_d  = 1'b0;
    done_d      = 1'b0;
    load_buf    = 1'b0;
    case (state_q)
      SQ_IDLE: begin
        if (start_i) begin
          if (out_len_i != '0) begin
            remaining_d = out_len_i;
            lane_d      = '0;
            state_d     = SQ_WAIT_STATE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SQ_WAIT_STATE: begin
        if (state_valid_i) begin
          load_buf = 1'b1;
          state_d  = SQ_STREAM;
        end
      end
      SQ_STREAM: begin
        if (out_ready_i) begin
          remaining_d = remaining_q - 1'b1;
          // Completion wins over rate exhaustion: no trailing permutation request.
          if (remaining_q == ONE_LEFT) begin
            state_d = SQ_IDLE;
            done_d  = 1'b1;
          end else if (lane_q == LAST_LANE) begin
            lane_d     = '0;
            perm_req_d = 1'b1;
            state_d    = SQ_WAIT_STATE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SQ_IDLE;
      state_buf   <= '0;
      lane_q      <= '0;
      remaining_q <= '0;
      perm_req_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      remaining_q <= remaining_d;
      perm_req_q  <= perm_req_d;
      done_q      <= done_d;
      if (load_buf) begin
        state_buf <= state_i;
      end
    end
  end

  assign out_valid_o = (state_q == SQ_STREAM);
  assign out_data_o  = out_valid_o ? sel_lane : '0;
  assign out_last_o  = out_valid_o && (remaining_q == ONE_LEFT);
  assign busy_o      = (state_q != SQ_IDLE);
  assign perm_req_o  = perm_req_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: sequence-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_keccak_squeeze;
  import keccak_pkg::*;

  localparam int R  = 21;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [LW-1:0] out_len_i;
  state_t        state_i;
  logic          state_valid_i;
  logic          perm_req_o;
  lane_t         out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          out_last_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk = ~clk;

  keccak_squeeze #(.RATE_LANES(R), .LEN_W(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .out_len_i     (out_len_i),
    .state_i       (state_i),
    .state_valid_i (state_valid_i),
    .perm_req_o    (perm_req_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: k-th lane of a request is lane k%R of the (k/R)-th state delivered.
  bit     m_active;
  int     m_issued;
  int     m_total;
  state_t m_blocks[$];
  bit     m_perm;
  bit     m_done;

  function automatic lane_t word_at(input state_t s, input int l);
    return s[l % 5][l / 5];
  endfunction

  function automatic bit m_valid();
    return m_active && (m_blocks.size() > m_issued / R);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_issued = 0;
      m_total  = 0;
      m_blocks.delete();
      m_perm   = 1'b0;
      m_done   = 1'b0;
    end else begin
      bit ev;
      ev     = m_valid();
      m_perm = 1'b0;
      m_done = 1'b0;
      if (!m_active) begin
        if (start_i) begin
          if (out_len_i != 0) begin
            m_active = 1'b1;
            m_total  = int'(out_len_i);
            m_issued = 0;
            m_blocks.delete();
          end else begin
            m_done = 1'b1;
          end
        end
      end else if (m_blocks.size() == m_issued / R) begin
        if (state_valid_i) m_blocks.push_back(state_i);
      end else if (ev && out_ready_i) begin
        m_issued++;
        if (m_issued == m_total) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else if (m_issued % R == 0) begin
          m_perm = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = m_valid();
    chk("out_valid", out_valid_o, ev);
    chk("busy", busy_o, m_active);
    chk("perm_req", perm_req_o, m_perm);
    chk("done", done_o, m_done);
    chk("out_last", out_last_o, ev && (m_issued == m_total - 1));
    if (ev) chk("out_data", out_data_o, word_at(m_blocks[m_issued / R], m_issued % R));
  end

  // Capture of actual handshakes and pulses for the directed literal checks.
  lane_t cap_d[$];
  bit    cap_l[$];
  int    perm_cnt;
  int    done_cnt;

  always @(negedge clk) begin
    if (rst) begin
      if (out_valid_o && out_ready_i) begin
        cap_d.push_back(out_data_o);
        cap_l.push_back(out_last_o);
      end
      if (perm_req_o) perm_cnt++;
      if (done_o) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    perm_cnt = 0;
    done_cnt = 0;
  endtask

  function automatic state_t xy_state(input logic [63:0] base);
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = base + 64'(x * 16 + y);
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic begin_req(input int len, input state_t s);
    start_i   = 1'b1;
    out_len_i = LW'(len);
    tick();
    start_i       = 1'b0;
    state_i       = s;
    state_valid_i = 1'b1;
    tick();
    state_valid_i = 1'b0;
  endtask

  initial begin
    state_t s1, s2;
    int nlast;
    rst           = 1'b0;
    start_i       = 1'b0;
    out_len_i     = '0;
    state_i       = '0;
    state_valid_i = 1'b0;
    out_ready_i   = 1'b1;
    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_last", out_last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_perm", perm_req_o, 0);
    chk("rst_done", done_o, 0);
    rst = 1'b1;
    tick();

    // len=3 with coordinate-tagged state
    clear_cap();
    begin_req(3, xy_state(64'h0));
    chk("t1_valid_t2", out_valid_o, 1);
    repeat (6) tick();
    chk("t1_count", cap_d.size(), 3);
    chk("t1_d0", cap_d[0], 64'h00);
    chk("t1_d1", cap_d[1], 64'h10);
    chk("t1_d2", cap_d[2], 64'h20);
    chk("t1_last", {cap_l[0], cap_l[1], cap_l[2]}, 3'b001);
    chk("t1_perm", perm_cnt, 0);
    chk("t1_done", done_cnt, 1);

    // len=21: exactly one block, no trailing permutation
    clear_cap();
    begin_req(21, xy_state(64'h0));
    repeat (25) tick();
    nlast = 0;
    foreach (cap_l[i]) nlast += int'(cap_l[i]);
    chk("t2_count", cap_d.size(), 21);
    chk("t2_d20", cap_d[20], 64'h04);
    chk("t2_last20", cap_l[20], 1);
    chk("t2_nlast", nlast, 1);
    chk("t2_perm", perm_cnt, 0);
    chk("t2_done", done_cnt, 1);

    // len=22: permutation request, new state delivered 4 cycles later
    clear_cap();
    begin_req(22, xy_state(64'h0));
    for (int i = 0; i < 60 && !perm_req_o; i++) tick();
    chk("t3_perm_seen", perm_req_o, 1);
    repeat (4) tick();
    state_i       = xy_state(64'hA500);
    state_valid_i = 1'b1;
    tick();
    state_valid_i = 1'b0;
    repeat (4) tick();
    chk("t3_count", cap_d.size(), 22);
    chk("t3_d21", cap_d[21], 64'hA500);
    chk("t3_last21", cap_l[21], 1);
    chk("t3_perm", perm_cnt, 1);
    chk("t3_done", done_cnt, 1);

    // Backpressure mid-stream
    clear_cap();
    begin_req(5, xy_state(64'h0));
    repeat (2) tick();
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_data", out_data_o, 64'h20);
      chk("t4_stall_last", out_last_o, 0);
    end
    out_ready_i = 1'b1;
    repeat (6) tick();
    chk("t4_count", cap_d.size(), 5);
    for (int i = 0; i < 5; i++) chk("t4_data", cap_d[i], 64'(i * 16));
    chk("t4_done", done_cnt, 1);

    // Zero-length request
    start_i   = 1'b1;
    out_len_i = '0;
    tick();
    start_i = 1'b0;
    chk("t5_done", done_o, 1);
    chk("t5_busy", busy_o, 0);
    chk("t5_valid", out_valid_o, 0);
    chk("t5_perm", perm_req_o, 0);
    tick();
    chk("t5_done_pulse", done_o, 0);

    // Reset during streaming at lane 7
    s1 = rand_state();
    begin_req(30, s1);
    repeat (7) tick();
    chk("t6_lane7", out_data_o, s1[2][1]);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid_o, 0);
    chk("t6_rst_data", out_data_o, 0);
    chk("t6_rst_last", out_last_o, 0);
    chk("t6_rst_busy", busy_o, 0);
    #2;
    rst = 1'b1;
    tick();
    state_i       = rand_state();
    state_valid_i = 1'b1;
    tick();
    state_valid_i = 1'b0;
    tick();
    chk("t6_idle_valid", out_valid_o, 0);
    clear_cap();
    s2 = rand_state();
    begin_req(2, s2);
    repeat (4) tick();
    chk("t6_count", cap_d.size(), 2);
    chk("t6_d0", cap_d[0], s2[0][0]);
    chk("t6_d1", cap_d[1], s2[1][0]);

    // Randomized traffic, including ignored starts/states and occasional resets
    for (int c = 0; c < 4000; c++) begin
      start_i       = ($urandom % 10 == 0);
      out_len_i     = LW'($urandom_range(0, 50));
      state_valid_i = ($urandom % 3 == 0);
      state_i       = rand_state();
      out_ready_i   = ($urandom % 4 != 0);
      if ($urandom % 700 == 0) begin
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      tick();
    end
    start_i       = 1'b0;
    state_valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
